filter_config_ctrl: RTL and testbench
=====================================

Name: filter_config_ctrl

Overview:
- Configuration sequencer for the image filter chain: greyscale → threshold 1 → blur → threshold 2 → edge.
- Accepts register writes for stage enables and the two threshold levels into shadow registers.
- Commits the shadow set atomically at a line (HSync) or frame (VSync) boundary, so a filter reconfiguration never tears a line.
- After each commit, asserts Blank for a programmable number of cycles while the filter pipeline flushes; also maintains a per-frame line counter.

Parameters:
- SETTLE_CYCLES, 4: cycles Blank is held after a commit (filter pipeline depth); 0 means no blanking.
- LINE_W, 11: width of LineCount.
- ENABLES_RST, 6'h1F: reset value of Enables and its shadow.
- THRESH1_RST, 8'd200: reset value of Thresh1 and its shadow.
- THRESH2_RST, 8'd255: reset value of Thresh2 and its shadow.

Ports:
- CLK  in  1  pixel clock.
- RST  in  1  synchronous reset, active-high.
- HSync  in  1  line sync; the rising edge marks a line boundary.
- VSync  in  1  frame sync; the rising edge marks a frame boundary.
- WrValid  in  1  config write request.
- WrReady  out  1  controller can accept a write.
- WrAddr  in  2  0 = enables, 1 = thresh1, 2 = thresh2, 3 = control.
- WrData  in  8  write data.
- Enables  out  6  live stage-enable vector to the filter chain.
- Thresh1  out  8  live threshold for stage 1.
- Thresh2  out  8  live threshold for stage 2.
- Pending  out  1  commit requested, not yet applied.
- Blank  out  1  filter output invalid; downstream substitutes black.
- LineCount  out  LINE_W  lines since the last VSync rising edge.

Behaviour:
- One clock, CLK. RST is synchronous, active-high, and overrides everything else.
- Reset values:
  - Enables and its shadow = ENABLES_RST.
  - Thresh1 and its shadow = THRESH1_RST.
  - Thresh2 and its shadow = THRESH2_RST.
  - Mode = 0; Pending = 0; Blank = 0; LineCount = 0; state = IDLE; settle counter = 0.
  - HSync_d = 0 and VSync_d = 0, so a sync input already high at reset release counts as an edge.
- Edge detect: registered HSync_d and VSync_d. hs_rise = HSync & ~HSync_d; vs_rise = VSync & ~VSync_d. Both are evaluated in the current cycle.
- Write handshake:
  - A write is accepted on a clock edge where WrValid & WrReady.
  - WrReady = (state == IDLE); it is combinational from state.
  - WrValid may stay high across non-ready cycles; data must then be held stable.
- Address decode:
  - addr 0: shadow_en <= WrData[5:0]; WrData[7:6] ignored.
  - addr 1: shadow_t1 <= WrData.
  - addr 2: shadow_t2 <= WrData.
  - addr 3: Mode <= WrData[1], applied immediately and not shadowed. If WrData[0] = 1, state goes to PENDING.
- State machine:
  - IDLE: accept writes. An addr-3 write with bit0 = 1 → PENDING, and Pending = 1 from the next cycle.
  - PENDING: WrReady = 0. The commit event is hs_rise when Mode = 0, or vs_rise when Mode = 1. On the commit edge:
    - Enables, Thresh1 and Thresh2 load from the shadows.
    - Pending clears.
    - If SETTLE_CYCLES > 0: Blank <= 1, counter <= SETTLE_CYCLES-1, go to SETTLE. Otherwise go to IDLE.
  - SETTLE: Blank = 1. The counter decrements each cycle. When the counter is 0: Blank <= 0, go to IDLE.
- Commit latency: the live outputs change on the first clock edge at which HSync (or VSync) is sampled high. No partial update is allowed; all three registers change on the same edge.
- Blank timing: Blank is high for exactly SETTLE_CYCLES consecutive cycles, starting in the cycle after the commit edge.
- A sync edge in IDLE or SETTLE does nothing to the config registers. Edges are not queued.
- Shadows are untouched by commit. A re-commit with no intervening writes reapplies the same values.
- LineCount:
  - vs_rise → 0.
  - Otherwise hs_rise → +1, wrapping modulo 2^LINE_W.
  - When vs_rise and hs_rise occur in the same cycle: the count clears to 0 and does not increment.
- Mode = 1 with a same-cycle hs_rise and vs_rise: the commit occurs (the vs_rise qualifies).
- RST in any state discards a pending commit, restores all reset values and aborts Blank.

Test Plan:
- Reset: hold RST 2 cycles → Enables = 6'h1F, Thresh1 = 200, Thresh2 = 255, WrReady = 1, Pending = 0, Blank = 0, LineCount = 0.
- Line commit: write addr0 = 0x05, addr1 = 0x80, addr3 = 0x01; then pulse HSync 10 cycles later:
  - Before the edge: outputs unchanged, Pending = 1, WrReady = 0.
  - On the first HSync-high edge: Enables = 6'h05, Thresh1 = 0x80, Thresh2 = 255.
  - Blank = 1 for exactly 4 cycles, then WrReady = 1.
- Frame mode: write addr0 = 0x3F, addr3 = 0x03; pulse HSync 3 times → no change and Pending stays 1. Pulse VSync → Enables = 6'h3F, LineCount = 0.
- Back-pressure: hold WrValid with addr2 = 0x10 during PENDING → not accepted. After commit + settle it is accepted: shadow_t2 = 0x10, and Thresh2 stays unchanged until the next commit.
- Line counter: after VSync, give 5 HSync pulses → LineCount = 5. Then HSync and VSync rising in the same cycle → LineCount = 0.
- Reset mid-operation: assert RST while in PENDING and while Blank = 1 → next cycle all outputs at reset values; a following HSync causes no commit.

Source files
------------

// File: rtl/filter_config_ctrl.sv
// Configuration sequencer for the image filter chain: shadowed enables and
// thresholds committed atomically on a line or frame boundary, then blanked.
module filter_config_ctrl #(
  parameter int          SETTLE_CYCLES = 4,
  parameter int          LINE_W        = 11,
  parameter logic [5:0]  ENABLES_RST   = 6'h1F,
  parameter logic [7:0]  THRESH1_RST   = 8'd200,
  parameter logic [7:0]  THRESH2_RST   = 8'd255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSync,
  input  logic              VSync,
  input  logic              WrValid,
  output logic              WrReady,
  input  logic [1:0]        WrAddr,
  input  logic [7:0]        WrData,
  output logic [5:0]        Enables,
  output logic [7:0]        Thresh1,
  output logic [7:0]        Thresh2,
  output logic              Pending,
  output logic              Blank,
  output logic [LINE_W-1:0] LineCount
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PENDING, SETTLE} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [5:0]       shadow_en;
  logic [7:0]       shadow_t1;
  logic [7:0]       shadow_t2;
  logic             mode;
  logic             hsync_d;
  logic             vsync_d;
  logic             hs_rise;
  logic             vs_rise;
  logic             commit;

  assign hs_rise = HSync & ~hsync_d;
  assign vs_rise = VSync & ~vsync_d;
  // Mode is frozen while pending, since writes are refused outside IDLE.
  assign commit  = mode ? vs_rise : hs_rise;
  assign WrReady = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_d   <= 1'b0;
      vsync_d   <= 1'b0;
      LineCount <= '0;
    end else begin
      hsync_d <= HSync;
      vsync_d <= VSync;
      if (vs_rise)      LineCount <= '0;
      else if (hs_rise) LineCount <= LineCount + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      settle_cnt <= '0;
      shadow_en  <= ENABLES_RST;
      shadow_t1  <= THRESH1_RST;
      shadow_t2  <= THRESH2_RST;
      Enables    <= ENABLES_RST;
      Thresh1    <= THRESH1_RST;
      Thresh2    <= THRESH2_RST;
      mode       <= 1'b0;
      Pending    <= 1'b0;
      Blank      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (WrValid) begin
            case (WrAddr)
              2'd0: shadow_en <= WrData[5:0];
              2'd1: shadow_t1 <= WrData;
              2'd2: shadow_t2 <= WrData;
              default: begin
                mode <= WrData[1];
                if (WrData[0]) begin
                  Pending <= 1'b1;
                  state   <= PENDING;
                end
              end
            endcase
          end
        end
        PENDING: begin
          if (commit) begin
            Enables <= shadow_en;
            Thresh1 <= shadow_t1;
            Thresh2 <= shadow_t2;
            Pending <= 1'b0;
            if (SETTLE_CYCLES > 0) begin
              Blank      <= 1'b1;
              settle_cnt <= SETTLE_INIT;
              state      <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            Blank <= 1'b0;
            state <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_config_ctrl.sv
// Scoreboard bench for filter_config_ctrl: directed test-plan sequences then
// random traffic, checked cycle-by-cycle against a behavioural model.
module tb_filter_config_ctrl;

  localparam int S      = 4;
  localparam int LINE_W = 11;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              HSync = 1'b0, VSync = 1'b0;
  logic              WrValid = 1'b0;
  logic              WrReady;
  logic [1:0]        WrAddr = '0;
  logic [7:0]        WrData = '0;
  logic [5:0]        Enables;
  logic [7:0]        Thresh1, Thresh2;
  logic              Pending, Blank;
  logic [LINE_W-1:0] LineCount;

  filter_config_ctrl #(.SETTLE_CYCLES(S), .LINE_W(LINE_W)) dut (
    .CLK(CLK), .RST(RST), .HSync(HSync), .VSync(VSync),
    .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
    .Enables(Enables), .Thresh1(Thresh1), .Thresh2(Thresh2),
    .Pending(Pending), .Blank(Blank), .LineCount(LineCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int en, t1, t2, pend, blank, line, rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain integers, blanking as a remaining-cycle budget.
  int m_sh_en, m_sh_t1, m_sh_t2, m_en, m_t1, m_t2;
  int m_mode, m_pend, m_blank_left, m_line, m_hs_prev, m_vs_prev;

  function automatic void model_reset();
    m_sh_en = 'h1F; m_sh_t1 = 200; m_sh_t2 = 255;
    m_en = 'h1F; m_t1 = 200; m_t2 = 255;
    m_mode = 0; m_pend = 0; m_blank_left = 0; m_line = 0;
    m_hs_prev = 0; m_vs_prev = 0;
  endfunction

  function automatic int m_ready();
    return (m_pend == 0 && m_blank_left == 0) ? 1 : 0;
  endfunction

  task automatic step(input bit rst, input bit hs, input bit vs,
                      input bit wv, input int wa, input int wd);
    exp_t e;
    bit   hr, vr, acc;
    @(negedge CLK);
    RST = rst; HSync = hs; VSync = vs; WrValid = wv;
    WrAddr = 2'(wa); WrData = 8'(wd);
    if (rst) begin
      model_reset();
    end else begin
      hr  = hs && !m_hs_prev;
      vr  = vs && !m_vs_prev;
      acc = wv && m_ready() == 1;
      if (m_pend == 1 && (m_mode == 1 ? vr : hr)) begin
        m_en = m_sh_en; m_t1 = m_sh_t1; m_t2 = m_sh_t2;
        m_pend = 0; m_blank_left = S;
      end else if (m_blank_left > 0) begin
        m_blank_left--;
      end
      if (acc) begin
        case (wa & 3)
          0: m_sh_en = wd & 'h3F;
          1: m_sh_t1 = wd & 'hFF;
          2: m_sh_t2 = wd & 'hFF;
          default: begin
            m_mode = (wd >> 1) & 1;
            if (wd & 1) m_pend = 1;
          end
        endcase
      end
      if (vr)      m_line = 0;
      else if (hr) m_line = (m_line + 1) % (1 << LINE_W);
      m_hs_prev = hs; m_vs_prev = vs;
    end
    e.en = m_en; e.t1 = m_t1; e.t2 = m_t2; e.pend = m_pend;
    e.blank = (m_blank_left > 0) ? 1 : 0; e.line = m_line; e.rdy = m_ready();
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("Enables",   int'(Enables),   e.en);
      check("Thresh1",   int'(Thresh1),   e.t1);
      check("Thresh2",   int'(Thresh2),   e.t2);
      check("Pending",   int'(Pending),   e.pend);
      check("Blank",     int'(Blank),     e.blank);
      check("LineCount", int'(LineCount), e.line);
      check("WrReady",   int'(WrReady),   e.rdy);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int a, input int d);
    step(0, 0, 0, 1, a, d);
  endtask
  task automatic hpulse();
    step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic vpulse();
    step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    // Line commit
    wr(0, 'h05); wr(1, 'h80); wr(3, 'h01);
    idle(10); hpulse(); idle(6);
    // Frame mode: HSync ignored, VSync commits
    wr(0, 'h3F); wr(3, 'h03);
    hpulse(); hpulse(); hpulse(); idle(2);
    vpulse(); idle(6);
    // Back-pressure: write to thresh2 held through pending and settle
    wr(3, 'h01);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2, 'h10);
    step(0, 1, 0, 1, 2, 'h10);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 2, 'h10);
    idle(2); wr(3, 'h01); hpulse(); idle(6);
    // Line counter, then simultaneous edges
    vpulse();
    for (int i = 0; i < 5; i++) hpulse();
    step(0, 1, 1, 0, 0, 0); idle(2);
    // Reset during PENDING and during Blank
    wr(3, 'h01); idle(2); step(1, 0, 0, 0, 0, 0); hpulse(); idle(2);
    wr(0, 'h0A); wr(3, 'h01); hpulse(); step(1, 0, 0, 0, 0, 0); hpulse(); idle(2);
    // Frame mode with same-cycle HSync/VSync rise
    wr(2, 'h33); wr(3, 'h03); idle(2); step(0, 1, 1, 0, 0, 0); idle(6);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)));
    end
    idle(1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
